neopix_frame_sequencer: RTL and testbench
=========================================

# neopix_frame_sequencer

Upstream stage of the NeopixelController on the pong board. Game/render logic writes 24-bit colors into an 8-entry pixel buffer at any time. This block turns those colors into a controlled stream of `load` pulses, one per pixel, followed by a single `go`. It then tracks the controller's `ready` until transmission ends, either on demand or on a periodic refresh tick.

## Interface
Parameters:
- `NUM_PIXELS`, 8: pixels in the strip, which is also the buffer depth.
- `PIX_W`, 3: pixel index width, equal to $clog2(NUM_PIXELS).
- `REFRESH_CYCLES`, 833_333: clock cycles per auto-refresh tick (60 Hz at 50 MHz).
- `DROP_TIMEOUT`, 4: maximum cycles to wait for `ctrl_ready` to fall after `go`.

Ports:
- `CLOCK_50`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `wr_en`  in  1  write `wr_color` into buffer entry `wr_pixel`.
- `wr_pixel`  in  PIX_W  buffer write index.
- `wr_color`  in  24  color as {R[23:16], G[15:8], B[7:0]}.
- `frame_req`  in  1  request one full frame; level or pulse, sampled each cycle.
- `auto_en`  in  1  enable frames on refresh ticks when the buffer is dirty.
- `ctrl_ready`  in  1  NeopixelController `ready`.
- `load`  out  1  one-cycle pulse that loads `red/green/blue` into `pixel`.
- `go`  out  1  one-cycle pulse that starts transmission.
- `pixel`  out  PIX_W  index presented with `load`.
- `red`, `green`, `blue`  out  8 each  color presented with `load`.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- **Buffer:** `NUM_PIXELS`×24 registers, reset to 0.
  - A write with `wr_en` is applied on the next edge and sets `dirty`.
  - A write with `wr_pixel ≥ NUM_PIXELS` is ignored and does not set `dirty`.
- **Refresh timer:** free-running counter from 0 to `REFRESH_CYCLES`-1.
  - `tick` is high on the wrap cycle.
  - The counter runs regardless of `auto_en`.
- **pending flag:** set by `frame_req`, or by `tick && auto_en && dirty`. It is cleared when a frame starts.
- **State machine:**
  - **IDLE:** if `pending` is set, clear `pending` and `dirty`, set idx=0, go to LOAD.
  - **LOAD:** when `ctrl_ready`=1, drive `load`=1 with `pixel`=idx and colors from buffer[idx], then increment idx. After idx `NUM_PIXELS`-1 is issued, go to GO. While `ctrl_ready`=0, stall with `load`=0.
  - **GO:** when `ctrl_ready`=1, drive `go`=1 for one cycle, then go to DROP.
  - **DROP:** wait for `ctrl_ready`=0, then go to TX. If `DROP_TIMEOUT` cycles pass with no drop, go directly to DONE.
  - **TX:** wait for `ctrl_ready`=1, then go to DONE.
  - **DONE:** pulse `frame_done` for one cycle, then go to IDLE.
- **Buffer reads:** each `load` samples the buffer at issue time.
  - A write to a pixel not yet loaded is transmitted in the current frame.
  - A write to a pixel already loaded re-sets `dirty` and is sent in the next frame.
- **Simultaneous events:**
  - A write in the same cycle as a frame start leaves `dirty`=1 (write wins).
  - `frame_req` or a qualifying tick while `busy` sets `pending`, giving exactly one extra frame after DONE. Multiple requests collapse into one.
- **Reset mid-frame:** all state returns to IDLE immediately and the buffer is cleared. No partial `load` or `go` is emitted after `reset_n` falls.

## Timing
- **Reset values:** `load`, `go`, `frame_done`, `busy`, `pixel`, `red`, `green`, `blue` all 0. Internal `dirty`, `pending`, timer, and idx all 0.
- **Outputs are registered:**
  - `load`/`go` appear one cycle after the state decision.
  - `pixel`/color are valid in the same cycle as `load`, and are 0 when `load`=0.
- **Start latency:** a `frame_req` sampled in IDLE gives `busy`=1 next cycle; the first `load` comes no earlier than the second cycle.
- **Minimum frame length:** with `ctrl_ready` held high, `load` occurs on `NUM_PIXELS` consecutive cycles.
- **Pulse spacing:** `load` and `go` are never asserted together, and `go` is never asserted twice without an intervening DROP/TX.

## Structure
- **Shared package `neopix_pkg`:**
  - `color_t` struct {r, g, b}, 8 bits each.
  - State enum `seq_state_t` {IDLE, LOAD, GO, DROP, TX, DONE}.
  - Default `NUM_PIXELS` and `REFRESH_CYCLES` constants.
- **Sub-module `refresh_timer`:** parameterized by `REFRESH_CYCLES`, with a `tick` output.
- The buffer and FSM stay in the top module.

## Test plan
- **Basic frame:** after reset, write pixel 3=24'hFF0000, pulse `frame_req` with `ctrl_ready`=1. Expect 8 `load` pulses on consecutive cycles with `pixel` 0..7, only pixel 3 carrying red=FF. Then one `go`; drop `ctrl_ready` for 100 cycles, raise it → `frame_done` once, `busy`=0.
- **Backpressure:** hold `ctrl_ready`=0 for 5 cycles during LOAD after pixel 2 → no `load` during the hold, pixel 3 is issued on the first cycle `ready` returns, no pixel skipped or repeated.
- **Auto refresh:** `REFRESH_CYCLES`=20, `auto_en`=1.
  - With no writes, no frame is sent.
  - After one write, exactly one frame starts at the next tick, and no further frames follow without new writes.
- **Mid-frame write and request:** during TX, write pixel 0 and pulse `frame_req` twice → exactly one more frame follows, carrying the new pixel 0 value.
- **Drop timeout:** controller never drops `ctrl_ready` after `go` → `frame_done` after `DROP_TIMEOUT` cycles, FSM back to IDLE.
- **Reset mid-frame:** assert `reset_n`=0 during LOAD at pixel 4 → all outputs 0 asynchronously. After release, no `load` appears until a new `frame_req`, and all buffer entries read 0.

Source files
------------

// File: rtl/neopix_frame_sequencer_pkg.sv
// Shared types and defaults for the neopixel frame sequencer.
package neopix_pkg;

    localparam int unsigned NUM_PIXELS_DEF     = 8;
    localparam int unsigned REFRESH_CYCLES_DEF = 833_333;
    localparam int unsigned COLOR_W            = 8;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } color_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GO,
        DROP,
        TX,
        DONE
    } seq_state_t;

endpackage

// File: rtl/neopix_frame_sequencer_if.sv
// Pixel-write, frame-control and controller-facing signals of the frame sequencer.
interface neopix_frame_sequencer_if
    import neopix_pkg::*;
#(
    parameter int unsigned PIX_W = 3
) ();

    logic                   wr_en;
    logic [PIX_W-1:0]       wr_pixel;
    logic [3*COLOR_W-1:0]   wr_color;
    logic                   frame_req;
    logic                   auto_en;
    logic                   ctrl_ready;
    logic                   load;
    logic                   go;
    logic [PIX_W-1:0]       pixel;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   busy;
    logic                   frame_done;

    modport master (
        output wr_en, wr_pixel, wr_color, frame_req, auto_en, ctrl_ready,
        input  load, go, pixel, red, green, blue, busy, frame_done
    );

    modport slave (
        input  wr_en, wr_pixel, wr_color, frame_req, auto_en, ctrl_ready,
        output load, go, pixel, red, green, blue, busy, frame_done
    );

endinterface

// File: rtl/neopix_frame_sequencer_refresh_timer.sv
// Free-running refresh counter; tick_o is high while the counter sits on its wrap value.
module refresh_timer
    import neopix_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/neopix_frame_sequencer.sv
// Pixel buffer plus frame FSM that streams load pulses and a go to the neopixel controller.
module neopix_frame_sequencer
    import neopix_pkg::*;
#(
    parameter int unsigned NUM_PIXELS     = NUM_PIXELS_DEF,
    parameter int unsigned PIX_W          = $clog2(NUM_PIXELS),
    parameter int unsigned REFRESH_CYCLES = REFRESH_CYCLES_DEF,
    parameter int unsigned DROP_TIMEOUT   = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    neopix_frame_sequencer_if.slave     bus
);

    localparam int unsigned DROP_W = $clog2(DROP_TIMEOUT + 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_PIXELS - 1);
    localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_TIMEOUT - 1);

    color_t            buf_q [NUM_PIXELS];
    seq_state_t        state_q, state_d;
    logic [PIX_W-1:0]  idx_q, idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              dirty_q, dirty_d;
    logic              pending_q, pending_d;
    logic              load_q, load_d;
    logic              go_q, go_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    color_t            color_q, color_d;
    logic              tick;
    logic              wr_ok;

    refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .tick_o (tick)
    );

    assign wr_ok = bus.wr_en && (32'(bus.wr_pixel) < NUM_PIXELS);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_PIXELS); i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_ok) begin
            buf_q[bus.wr_pixel] <= bus.wr_color;
        end
    end

    // pending sees this cycle's request so a request in IDLE starts the frame on the next edge
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drop_d    = drop_q;
        dirty_d   = dirty_q;
        pending_d = pending_q;
        load_d    = 1'b0;
        go_d      = 1'b0;
        done_d    = 1'b0;
        pixel_d   = '0;
        color_d   = '0;

        if (bus.frame_req || (tick && bus.auto_en && dirty_q)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_d) begin
                    pending_d = 1'b0;
                    dirty_d   = 1'b0;
                    idx_d     = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (bus.ctrl_ready) begin
                    load_d  = 1'b1;
                    pixel_d = idx_q;
                    color_d = buf_q[idx_q];
                    idx_d   = idx_q + PIX_W'(1);
                    if (idx_q == LAST_PIX) begin
                        state_d = GO;
                    end
                end
            end
            GO: begin
                if (bus.ctrl_ready) begin
                    go_d    = 1'b1;
                    drop_d  = '0;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!bus.ctrl_ready) begin
                    state_d = TX;
                end else if (drop_q == DROP_LAST) begin
                    state_d = DONE;
                end else begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end
            TX: begin
                if (bus.ctrl_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a write landing on the frame-start edge keeps the buffer dirty
        if (wr_ok) begin
            dirty_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            drop_q    <= '0;
            dirty_q   <= 1'b0;
            pending_q <= 1'b0;
            load_q    <= 1'b0;
            go_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            pixel_q   <= '0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            load_q    <= load_d;
            go_q      <= go_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            pixel_q   <= pixel_d;
            color_q   <= color_d;
        end
    end

    assign bus.load       = load_q;
    assign bus.go         = go_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;
    assign bus.pixel      = pixel_q;
    assign bus.red        = color_q.r;
    assign bus.green      = color_q.g;
    assign bus.blue       = color_q.b;

endmodule

// File: tb/tb_neopix_frame_sequencer.sv
// Directed bench for neopix_frame_sequencer with a small controller model and a load/go monitor.
module tb_neopix_frame_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic man_en = 1'b1;
    logic man_val = 1'b1;
    logic [7:0] mdl_cnt;

    int total = 0;
    int bad = 0;

    int load_cnt = 0;
    int go_cnt = 0;
    int done_cnt = 0;
    int seq_err = 0;
    int overlap = 0;
    logic [23:0] frame_col [8];
    logic [2:0]  exp_pix;

    always #5 clk = ~clk;

    neopix_frame_sequencer_if #(.PIX_W(3)) bus ();

    neopix_frame_sequencer #(
        .NUM_PIXELS     (8),
        .PIX_W          (3),
        .REFRESH_CYCLES (20),
        .DROP_TIMEOUT   (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    // controller model: drops ready for three cycles after seeing go, unless manually overridden
    assign bus.ctrl_ready = man_en ? man_val : (mdl_cnt == 8'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             mdl_cnt <= 8'd0;
        else if (mdl_cnt != 0)  mdl_cnt <= mdl_cnt - 8'd1;
        else if (bus.go)        mdl_cnt <= 8'd3;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pix <= 3'd0;
        end else begin
            if (bus.load) begin
                load_cnt <= load_cnt + 1;
                frame_col[bus.pixel] <= {bus.red, bus.green, bus.blue};
                if (bus.pixel != exp_pix) seq_err <= seq_err + 1;
                exp_pix <= bus.pixel + 3'd1;
            end
            if (bus.go)              go_cnt   <= go_cnt + 1;
            if (bus.frame_done)      done_cnt <= done_cnt + 1;
            if (bus.load && bus.go)  overlap  <= overlap + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    initial begin
        int l0, g0, d0;

        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_pixel = 3'd0;
        bus.wr_color = 24'h0;
        bus.frame_req = 1'b0;
        bus.auto_en = 1'b0;
        step(3);
        chk("reset_ctrl", 32'({bus.load, bus.go, bus.frame_done, bus.busy, bus.pixel}), 32'd0);
        chk("reset_color", 32'({bus.red, bus.green, bus.blue}), 32'd0);
        rst_n = 1'b1;
        step(2);
        chk("idle_after_reset", 32'({bus.busy, bus.load}), 32'd0);

        // basic frame
        bus.wr_en = 1'b1; bus.wr_pixel = 3'd3; bus.wr_color = 24'hFF0000;
        step(1);
        bus.wr_en = 1'b0; bus.frame_req = 1'b1;
        l0 = load_cnt; g0 = go_cnt; d0 = done_cnt;
        step(1);
        bus.frame_req = 1'b0;
        chk("start_busy", 32'({bus.busy, bus.load}), 32'(2'b10));
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("basic_load", 32'({bus.load, bus.pixel, bus.red, bus.green, bus.blue}),
                32'({1'b1, 3'(i), (i == 3) ? 8'hFF : 8'h00, 16'h0000}));
        end
        step(1);
        chk("basic_go", 32'({bus.go, bus.load}), 32'(2'b10));
        man_val = 1'b0;
        step(100);
        chk("tx_hold_busy", 32'({bus.busy, bus.frame_done}), 32'(2'b10));
        man_val = 1'b1;
        wait_done(5, "basic_done");
        chk("basic_idle", 32'(bus.busy), 32'd0);
        chk("basic_counts", 32'({8'(load_cnt - l0), 8'(go_cnt - g0), 8'(done_cnt - d0)}),
            32'({8'd8, 8'd1, 8'd1}));

        // backpressure after pixel 2
        l0 = load_cnt; g0 = go_cnt; d0 = done_cnt;
        bus.frame_req = 1'b1;
        step(1);
        bus.frame_req = 1'b0;
        step(3);
        chk("bp_p2", 32'({bus.load, bus.pixel}), 32'({1'b1, 3'd2}));
        man_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_stall", 32'(bus.load), 32'd0);
        end
        man_val = 1'b1;
        for (int i = 3; i < 8; i++) begin
            step(1);
            chk("bp_resume", 32'({bus.load, bus.pixel, bus.red}),
                32'({1'b1, 3'(i), (i == 3) ? 8'hFF : 8'h00}));
        end
        man_en = 1'b0;
        wait_done(20, "bp_done");
        chk("bp_counts", 32'({8'(load_cnt - l0), 8'(go_cnt - g0), 8'(done_cnt - d0)}),
            32'({8'd8, 8'd1, 8'd1}));

        // auto refresh
        l0 = load_cnt; d0 = done_cnt;
        bus.auto_en = 1'b1;
        step(60);
        chk("auto_clean_idle", 32'({8'(load_cnt - l0), 7'd0, bus.busy}), 32'd0);
        bus.wr_en = 1'b1; bus.wr_pixel = 3'd5; bus.wr_color = 24'h00AB00;
        step(1);
        bus.wr_en = 1'b0;
        wait_done(60, "auto_done");
        chk("auto_p5", 32'(frame_col[5]), 32'h00AB00);
        chk("auto_p3", 32'(frame_col[3]), 32'hFF0000);
        step(60);
        chk("auto_one_frame", 32'({8'(load_cnt - l0), 8'(done_cnt - d0)}), 32'({8'd8, 8'd1}));
        bus.auto_en = 1'b0;

        // write and double request during TX
        man_en = 1'b1; man_val = 1'b1;
        l0 = load_cnt; g0 = go_cnt; d0 = done_cnt;
        bus.frame_req = 1'b1;
        step(1);
        bus.frame_req = 1'b0;
        step(9);
        chk("mf_go", 32'(bus.go), 32'd1);
        man_val = 1'b0;
        step(2);
        chk("mf_in_tx", 32'({bus.busy, bus.frame_done}), 32'(2'b10));
        bus.wr_en = 1'b1; bus.wr_pixel = 3'd0; bus.wr_color = 24'h0000CC; bus.frame_req = 1'b1;
        step(1);
        bus.wr_en = 1'b0; bus.frame_req = 1'b0;
        step(1);
        bus.frame_req = 1'b1;
        step(1);
        bus.frame_req = 1'b0;
        man_en = 1'b0;
        wait_done(10, "mf_done1");
        chk("mf_first_p0", 32'(frame_col[0]), 32'h000000);
        wait_done(40, "mf_done2");
        chk("mf_second_p0", 32'(frame_col[0]), 32'h0000CC);
        step(30);
        chk("mf_counts", 32'({8'(load_cnt - l0), 8'(go_cnt - g0), 8'(done_cnt - d0)}),
            32'({8'd16, 8'd2, 8'd2}));

        // drop timeout: ready never falls after go
        man_en = 1'b1; man_val = 1'b1;
        bus.frame_req = 1'b1;
        step(1);
        bus.frame_req = 1'b0;
        step(9);
        chk("to_go", 32'(bus.go), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("to_wait", 32'({bus.busy, bus.frame_done}), 32'(2'b10));
        end
        step(1);
        chk("to_done", 32'({bus.busy, bus.frame_done}), 32'(2'b01));
        step(1);
        chk("to_idle", 32'({bus.busy, bus.frame_done, bus.load}), 32'd0);

        // reset mid-frame at pixel 4
        bus.frame_req = 1'b1;
        step(1);
        bus.frame_req = 1'b0;
        step(5);
        chk("rst_p4", 32'({bus.load, bus.pixel}), 32'({1'b1, 3'd4}));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({bus.load, bus.go, bus.frame_done, bus.busy, bus.pixel,
                              bus.red, bus.green, bus.blue}), 32'd0);
        step(2);
        rst_n = 1'b1;
        l0 = load_cnt;
        step(20);
        chk("rst_no_load", 32'({8'(load_cnt - l0), 7'd0, bus.busy}), 32'd0);
        bus.frame_req = 1'b1;
        step(1);
        bus.frame_req = 1'b0;
        wait_done(40, "rst_frame_done");
        for (int i = 0; i < 8; i++) begin
            chk("rst_buf_clear", 32'(frame_col[i]), 32'd0);
        end
        chk("rst_frame_loads", 32'(load_cnt - l0), 32'd8);

        chk("no_load_go_overlap", 32'(overlap), 32'd0);
        chk("pixel_order", 32'(seq_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
